// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and
// the default operand width.
package serial_subtractor_pkg;

    localparam int DEF_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor: d = x - y - bi, with borrow-out bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (a - b - bin), LSB first, one bit per clock.
// A single full-subtractor cell is shared across all bit positions; the
// borrow is carried between bits in a register.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    state_t          state_q;
    logic [W-1:0]    a_sr_q, b_sr_q, diff_q;
    logic            br_q, a_msb_q, b_msb_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q, bout_q, ovf_q;

    logic            fs_d, fs_bo;
    logic [W-1:0]    diff_d;
    logic [CW-1:0]   cnt_d;
    logic            ovf_d;

    full_subtractor u_fs (
        .x  (a_sr_q[0]),
        .y  (b_sr_q[0]),
        .bi (br_q),
        .d  (fs_d),
        .bo (fs_bo)
    );

    // Next values for the shifting result, counter and overflow flag.
    // On the last bit, fs_d is the result MSB, so overflow can be decided
    // in the same cycle and be valid while done is high.
    always_comb begin
        diff_d = {fs_d, diff_q[W-1:1]};
        cnt_d  = cnt_q + CW'(1);
        ovf_d  = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
    end

    // Control FSM plus datapath registers; DONE accepts a new start like IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        br_q    <= bin;
                        a_msb_q <= a[W-1];
                        b_msb_q <= b[W-1];
                        cnt_q   <= '0;
                        diff_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    diff_q <= diff_d;
                    a_sr_q <= a_sr_q >> 1;
                    b_sr_q <= b_sr_q >> 1;
                    br_q   <= fs_bo;
                    cnt_q  <= cnt_d;
                    if (cnt_q == LAST_BIT) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bout_q  <= fs_bo;
                        ovf_q   <= ovf_d;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed operations whose expected
// results are queued at issue time and checked when done pulses.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout, ovf;
    logic [W-1:0] diff;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t sb[$];

    serial_subtractor #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] d, input logic bo,
                                input logic ov, input int c);
        exp_t e;
        e.diff = d;
        e.bout = bo;
        e.ovf  = ov;
        e.cyc  = c;
        return e;
    endfunction

    // Monitor: pop and compare whenever the DUT pulses done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("diff", int'(diff), int'(e.diff));
                    chk("bout", int'(bout), int'(e.bout));
                    chk("ovf", int'(ovf), int'(e.ovf));
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_during_done", int'(busy), 0);
                end
            end
        end
    end

    // Issue one operation with a single-cycle start and wait for its result.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic tbin, input logic [W-1:0] ed,
                      input logic eb, input logic eo);
        @(posedge clk); #1;
        start = 1'b1; a = ta; b = tb_; bin = tbin;
        sb.push_back(mk(ed, eb, eo, cyc + 1 + W));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (W + 2) @(posedge clk);
    endtask

    initial begin
        int kc;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_bout", int'(bout), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst = 1'b0;

        op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // Reset 4 cycles into SHIFT: aborts, clears held results, no done
        @(posedge clk); #1;
        start = 1'b1; a = 8'h55; b = 8'h11; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_diff", int'(diff), 0);
        chk("abort_bout", int'(bout), 0);
        chk("abort_ovf", int'(ovf), 0);
        rst = 1'b0;
        repeat (W + 2) @(posedge clk);

        op(8'h0A, 8'h0F, 1'b0, 8'hFB, 1'b1, 1'b0);

        // Start held high: second operation follows after exactly W+1 cycles
        @(posedge clk); #1;
        start = 1'b1; a = 8'h00; b = 8'h00; bin = 1'b1;
        sb.push_back(mk(8'hFF, 1'b1, 1'b0, cyc + 1 + W));
        @(posedge clk); #1;
        kc = cyc;
        a = 8'h10; b = 8'h01; bin = 1'b0;
        sb.push_back(mk(8'h0F, 1'b0, 1'b0, kc + 2 * W + 1));
        repeat (W + 1) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (W + 2) @(posedge clk);

        // Start pulsed 3 cycles into SHIFT is ignored
        @(posedge clk); #1;
        start = 1'b1; a = 8'h40; b = 8'h20; bin = 1'b0;
        sb.push_back(mk(8'h20, 1'b0, 1'b0, cyc + 1 + W));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (W + 3) @(posedge clk);
        #1;

        chk("pending_results", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout, got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
